// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus stable-count debounce FSM with registered level and edge pulses.
// Optional rising-edge event counter (clr_cnt/evt_cnt ports) is built when DEBOUNCE_EVT_CNT_EN is defined.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_raw,
`ifdef DEBOUNCE_EVT_CNT_EN
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] evt_cnt,
`endif
  output logic             dout,
  output logic             rise_pulse,
  output logic             fall_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TermCnt = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] OneCnt  = CW'(1);

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_CHK_HI = 2'd1,
    S_HIGH   = 2'd2,
    S_CHK_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_syncIn;

  state_t        r_state;
  state_t        w_nxtState;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nxtCnt;
  logic          r_dout;
  logic          w_nxtDout;
  logic          r_rise;
  logic          w_nxtRise;
  logic          r_fall;
  logic          w_nxtFall;

  // Bit 0 takes the raw pin; the oldest stage is the only one the FSM ever looks at.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din_raw};
    end
  end

  assign w_syncIn = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_nxtState;
      r_cnt   <= w_nxtCnt;
      r_dout  <= w_nxtDout;
      r_rise  <= w_nxtRise;
      r_fall  <= w_nxtFall;
    end
  end

  // Entering a check state counts the first opposite sample as 1; any reversal drops back to the stable state.
  always_comb begin
    w_nxtState = r_state;
    w_nxtCnt   = r_cnt;
    w_nxtDout  = r_dout;
    w_nxtRise  = 1'b0;
    w_nxtFall  = 1'b0;
    case (r_state)
      S_LOW: begin
        if (w_syncIn) begin
          w_nxtState = S_CHK_HI;
          w_nxtCnt   = OneCnt;
        end
      end
      S_CHK_HI: begin
        if (!w_syncIn) begin
          w_nxtState = S_LOW;
          w_nxtCnt   = '0;
        end else if (r_cnt == TermCnt) begin
          w_nxtState = S_HIGH;
          w_nxtCnt   = '0;
          w_nxtDout  = 1'b1;
          w_nxtRise  = 1'b1;
        end else begin
          w_nxtCnt = r_cnt + OneCnt;
        end
      end
      S_HIGH: begin
        if (!w_syncIn) begin
          w_nxtState = S_CHK_LO;
          w_nxtCnt   = OneCnt;
        end
      end
      S_CHK_LO: begin
        if (w_syncIn) begin
          w_nxtState = S_HIGH;
          w_nxtCnt   = '0;
        end else if (r_cnt == TermCnt) begin
          w_nxtState = S_LOW;
          w_nxtCnt   = '0;
          w_nxtDout  = 1'b0;
          w_nxtFall  = 1'b1;
        end else begin
          w_nxtCnt = r_cnt + OneCnt;
        end
      end
      default: begin
        w_nxtState = S_LOW;
        w_nxtCnt   = '0;
        w_nxtDout  = 1'b0;
      end
    endcase
  end

  assign dout       = r_dout;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

`ifdef DEBOUNCE_EVT_CNT_EN
  logic [CNT_W-1:0] r_evtCnt;

  // Counts on the same edge that raises rise_pulse so evt_cnt moves together with dout; clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_evtCnt <= '0;
    end else if (clr_cnt) begin
      r_evtCnt <= '0;
    end else if (w_nxtRise && (r_evtCnt != {CNT_W{1'b1}})) begin
      r_evtCnt <= r_evtCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign evt_cnt = r_evtCnt;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: per-cycle table of held inputs and expected outputs plus reset/counter sequences.
// Counter checks (CNT_W=2) are compiled only when DEBOUNCE_EVT_CNT_EN is defined.
module tb_input_debouncer;

  localparam int CNT_W = 2;

  logic clk;
  logic rst;
  logic dinRaw;
  logic dout;
  logic risePulse;
  logic fallPulse;
`ifdef DEBOUNCE_EVT_CNT_EN
  logic             clrCnt;
  logic [CNT_W-1:0] evtCnt;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  typedef struct {
    logic din;
    int   hold;
    logic expDout;
    logic expRise;
    logic expFall;
  } vec_t;

  vec_t vecs[$];

  input_debouncer #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(16),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din_raw(dinRaw),
`ifdef DEBOUNCE_EVT_CNT_EN
    .clr_cnt(clrCnt),
    .evt_cnt(evtCnt),
`endif
    .dout(dout),
    .rise_pulse(risePulse),
    .fall_pulse(fallPulse)
  );

  initial begin
    clk = 1'b0;
    forever #100 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic eDout, input logic eRise, input logic eFall);
    checkOutput({tag, " dout"}, int'(dout), int'(eDout));
    checkOutput({tag, " rise"}, int'(risePulse), int'(eRise));
    checkOutput({tag, " fall"}, int'(fallPulse), int'(eFall));
  endtask

  function automatic void addVec(input logic din, input int hold, input logic eDout,
                                 input logic eRise, input logic eFall);
    vec_t v;
    v.din = din;
    v.hold = hold;
    v.expDout = eDout;
    v.expRise = eRise;
    v.expFall = eFall;
    vecs.push_back(v);
  endfunction

  // Each record holds din for 'hold' cycles and checks the outputs after every one of those edges.
  task automatic applyStimulus();
    for (int i = 0; i < vecs.size(); i++) begin
      dinRaw = vecs[i].din;
      for (int c = 0; c < vecs[i].hold; c++) begin
        tick();
        checkAll($sformatf("vec%0d.c%0d", i, c), vecs[i].expDout, vecs[i].expRise, vecs[i].expFall);
      end
    end
  endtask

`ifdef DEBOUNCE_EVT_CNT_EN
  task automatic press();
    dinRaw = 1'b1;
    repeat (20) tick();
    dinRaw = 1'b0;
    repeat (20) tick();
  endtask
`endif

  initial begin
    rst    = 1'b0;
    dinRaw = 1'b0;
`ifdef DEBOUNCE_EVT_CNT_EN
    clrCnt = 1'b0;
`endif

    // Settle: stable low, then clean rise held 40 cycles, then clean fall.
    addVec(1'b0, 5, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 17, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 1, 1'b1, 1'b1, 1'b0);
    addVec(1'b1, 22, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 17, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1, 1'b0, 1'b0, 1'b1);
    addVec(1'b0, 10, 1'b0, 1'b0, 1'b0);
    // Glitch of 10 cycles never reaches dout.
    addVec(1'b1, 10, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 25, 1'b0, 1'b0, 1'b0);
    // Bounce: 8 segments of 3 cycles, then steady high.
    for (int b = 0; b < 8; b++) addVec(((b % 2) == 0) ? 1'b1 : 1'b0, 3, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 17, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 1, 1'b1, 1'b1, 1'b0);
    addVec(1'b1, 10, 1'b1, 1'b0, 1'b0);

    // Reset held while din toggles: outputs stay low.
    #1;
    checkAll("rst.init", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      dinRaw = ~dinRaw;
      tick();
      checkAll($sformatf("rst.c%0d", i), 1'b0, 1'b0, 1'b0);
`ifdef DEBOUNCE_EVT_CNT_EN
      checkOutput($sformatf("rst.c%0d evt", i), int'(evtCnt), 0);
`endif
    end
    dinRaw = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] running %0d table records", vecs.size());
    applyStimulus();

    // Mid-fall reset: after 10 low cycles the FSM is in S_CHK_LO with cnt=8.
    dinRaw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkAll($sformatf("midrst.pre%0d", i), 1'b1, 1'b0, 1'b0);
    end
    #50;
    rst = 1'b0;
    #1;
    checkAll("midrst.async", 1'b0, 1'b0, 1'b0);
`ifdef DEBOUNCE_EVT_CNT_EN
    checkOutput("midrst.async evt", int'(evtCnt), 0);
`endif
    dinRaw = 1'b1;
    #40;
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      checkAll($sformatf("midrst.wait%0d", i), 1'b0, 1'b0, 1'b0);
    end
    tick();
    checkAll("midrst.rise", 1'b1, 1'b1, 1'b0);
    tick();
    checkAll("midrst.after", 1'b1, 1'b0, 1'b0);

`ifdef DEBOUNCE_EVT_CNT_EN
    checkOutput("evt.afterRst", int'(evtCnt), 1);
    dinRaw = 1'b0;
    repeat (20) tick();
    clrCnt = 1'b1;
    tick();
    clrCnt = 1'b0;
    checkOutput("evt.clr1", int'(evtCnt), 0);
    for (int p = 0; p < 3; p++) press();
    checkOutput("evt.three", int'(evtCnt), 3);
    clrCnt = 1'b1;
    tick();
    clrCnt = 1'b0;
    checkOutput("evt.clr2", int'(evtCnt), 0);
    // Clear on the same edge as a rise wins.
    dinRaw = 1'b1;
    repeat (17) tick();
    clrCnt = 1'b1;
    tick();
    clrCnt = 1'b0;
    checkAll("evt.clrRise", 1'b1, 1'b1, 1'b0);
    checkOutput("evt.clrRise evt", int'(evtCnt), 0);
    tick();
    checkOutput("evt.clrRise next", int'(evtCnt), 0);
    dinRaw = 1'b0;
    repeat (20) tick();
    press();
    press();
    checkOutput("evt.two", int'(evtCnt), 2);
    press();
    press();
    press();
    checkOutput("evt.sat", int'(evtCnt), 3);
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
